// File: rtl/sfq_sync_pulse_decoder.sv
// ----------------------------------------------------------------------------
// sfq_sync_pulse_decoder
//
// Receiver for toggle-encoded RSFQ cell outputs. Every SFQ pulse flips the
// q_in level, so one pulse bit per clock is recovered as q_in ^ q_prev. After
// a start request the block discards SKIP periods (cell clock-to-q latency),
// captures WIDTH pulse bits into a frame, compares that frame with the
// expectation latched at start, and holds the result on a valid/ready port
// until the consumer accepts it. Mismatching frames are tallied in a
// saturating counter.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      capture request, honoured only in IDLE
//   expect_mode  in   2      0=all zeros, 1=all ones, 2=expect_pat, 3=no check
//   expect_pat   in   WIDTH  expected frame for mode 2
//   q_in         in   1      toggle-encoded SFQ line
//   busy         out  1      high whenever the FSM is not in IDLE
//   frame_valid  out  1      frame_data / frame_err are valid
//   frame_ready  in   1      consumer accepts the frame
//   frame_data   out  WIDTH  decoded pulse bits, bit i = i-th captured period
//   frame_err    out  1      frame mismatched its expectation
//   err_count    out  CNT_W  mismatching frames seen, saturating
// ----------------------------------------------------------------------------
module sfq_sync_pulse_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int SKIP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       expect_mode,
  input  logic [WIDTH-1:0] expect_pat,
  input  logic             q_in,
  output logic             busy,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SK_W  = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [SK_W-1:0]  SK_LAST  = SK_W'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t           state;
  logic             q_prev;
  logic [IDX_W-1:0] cap_idx;
  logic [SK_W-1:0]  skip_cnt;
  logic [1:0]       mode_l;
  logic [WIDTH-1:0] pat_l;

  logic             pulse_bit;
  logic [WIDTH-1:0] cap_data;
  logic             cap_err;

  // Counter increment that sticks at all ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WIDTH-1:0] expected_of(input logic [1:0]       mode,
                                                   input logic [WIDTH-1:0] pat);
    case (mode)
      2'd0:    return '0;
      2'd1:    return '1;
      default: return pat;
    endcase
  endfunction

  // The error flag is decided on the last capture cycle, so it has to see the
  // frame including the bit being written in that same cycle.
  always_comb begin
    pulse_bit         = q_in ^ q_prev;
    cap_data          = frame_data;
    cap_data[cap_idx] = pulse_bit;
    cap_err           = (mode_l != 2'd3) &&
                        (|(cap_data ^ expected_of(mode_l, pat_l)));
  end

  // Expectation snapshot, taken only when a capture is accepted.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      mode_l <= expect_mode;
      pat_l  <= expect_pat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      q_prev      <= 1'b0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_data  <= '0;
      err_count   <= '0;
      cap_idx     <= '0;
      skip_cnt    <= '0;
    end else begin
      // Line level is tracked in every state so the first captured bit is
      // relative to the level just before capture begins.
      q_prev <= q_in;
      case (state)
        S_IDLE: begin
          if (start) begin
            cap_idx   <= '0;
            skip_cnt  <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b1;
            state     <= (SKIP > 0) ? S_SKIP : S_CAPTURE;
          end
        end
        S_SKIP: begin
          if (skip_cnt == SK_LAST) begin
            state <= S_CAPTURE;
          end else begin
            skip_cnt <= skip_cnt + SK_W'(1);
          end
        end
        S_CAPTURE: begin
          frame_data[cap_idx] <= pulse_bit;
          if (cap_idx == IDX_LAST) begin
            frame_err   <= cap_err;
            frame_valid <= 1'b1;
            state       <= S_HOLD;
            if (cap_err) begin
              err_count <= sat_inc(err_count);
            end
          end else begin
            cap_idx <= cap_idx + IDX_W'(1);
          end
        end
        S_HOLD: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfq_sync_pulse_decoder.sv
module tb_sfq_sync_pulse_decoder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] expect_mode;
  logic [7:0] expect_pat;
  logic       q_in;
  logic       frame_ready;

  logic        busy, frame_valid, frame_err;
  logic [7:0]  frame_data;
  logic [15:0] err_count;

  logic        busy2, frame_valid2, frame_err2;
  logic [7:0]  frame_data2;
  logic [1:0]  err_count2;

  int n_checks = 0;
  int n_fail   = 0;

  sfq_sync_pulse_decoder #(.WIDTH(8), .CNT_W(16), .SKIP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expect_mode(expect_mode),
    .expect_pat(expect_pat), .q_in(q_in), .busy(busy),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .frame_err(frame_err), .err_count(err_count)
  );

  sfq_sync_pulse_decoder #(.WIDTH(8), .CNT_W(2), .SKIP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .expect_mode(expect_mode),
    .expect_pat(expect_pat), .q_in(q_in), .busy(busy2),
    .frame_valid(frame_valid2), .frame_ready(frame_ready),
    .frame_data(frame_data2), .frame_err(frame_err2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Start a frame with the given expectation, then scramble the expectation
  // inputs; toggle once in the SKIP period if asked, and toggle q_in in each
  // capture period where bits[k] is set. Returns right after the HOLD edge.
  task automatic run_frame(input logic [1:0] mode, input logic [7:0] pat,
                           input logic skip_tgl, input logic [7:0] bits);
    expect_mode = mode;
    expect_pat  = pat;
    start       = 1'b1;
    step();
    start       = 1'b0;
    expect_mode = ~mode;
    expect_pat  = ~pat;
    check_val("busy_after_start", busy, 1);
    q_in = q_in ^ skip_tgl;
    step();
    for (int k = 0; k < 8; k++) begin
      q_in = q_in ^ bits[k];
      if (k == 7) check_val("valid_before_last", frame_valid, 0);
      step();
    end
    check_val("valid_latency", frame_valid, 1);
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    check_val("valid_drop", frame_valid, 0);
    check_val("idle_after_accept", busy, 0);
  endtask

  initial begin
    int exp2[4];
    int exp16[4];
    exp2  = '{1, 2, 3, 3};
    exp16 = '{1, 2, 3, 4};

    rst_n = 1'b0; start = 1'b0; expect_mode = 2'd0; expect_pat = 8'h00;
    q_in = 1'b0; frame_ready = 1'b0;
    step();
    step();
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", frame_valid, 0);
    check_val("rst_data", frame_data, 0);
    check_val("rst_err", frame_err, 0);
    check_val("rst_cnt", err_count, 0);
    rst_n = 1'b1;
    step();

    // 1: quiet line, mode 0
    run_frame(2'd0, 8'h00, 1'b0, 8'h00);
    check_val("t1_data", frame_data, 8'h00);
    check_val("t1_err", frame_err, 0);
    check_val("t1_cnt", err_count, 0);
    accept();

    // 2: single pulse in capture period 3
    run_frame(2'd0, 8'h00, 1'b0, 8'h08);
    check_val("t2_data", frame_data, 8'h08);
    check_val("t2_err", frame_err, 1);
    check_val("t2_cnt", err_count, 1);
    accept();

    // 3: toggling every clock, mode 1; SKIP toggle not recorded
    run_frame(2'd1, 8'h00, 1'b1, 8'hFF);
    check_val("t3_data", frame_data, 8'hFF);
    check_val("t3_err", frame_err, 0);
    accept();
    run_frame(2'd3, 8'h00, 1'b1, 8'h00);
    check_val("t3b_skip_dropped", frame_data, 8'h00);
    check_val("t3b_err", frame_err, 0);
    accept();

    // 4: pattern match, back-pressure for 5 cycles
    run_frame(2'd2, 8'hA5, 1'b0, 8'hA5);
    check_val("t4_data", frame_data, 8'hA5);
    check_val("t4_err", frame_err, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("t4_hold_valid", frame_valid, 1);
      check_val("t4_hold_data", frame_data, 8'hA5);
    end
    check_val("t4_cnt", err_count, 1);
    accept();

    // 5: counter saturation on the narrow instance
    reset_pulse();
    check_val("t5_cnt_rst", err_count, 0);
    check_val("t5_cnt2_rst", err_count2, 0);
    for (int f = 0; f < 4; f++) begin
      run_frame(2'd0, 8'h00, 1'b0, 8'h01);
      check_val("t5_err", frame_err2, 1);
      check_val("t5_cnt2", err_count2, exp2[f]);
      check_val("t5_cnt16", err_count, exp16[f]);
      accept();
    end

    // 6: reset mid-capture, then clean frame; start during HOLD ignored
    expect_mode = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      q_in = ~q_in;
      step();
    end
    check_val("t6_busy_mid", busy, 1);
    reset_pulse();
    check_val("t6_busy_rst", busy, 0);
    check_val("t6_valid_rst", frame_valid, 0);
    check_val("t6_cnt_rst", err_count, 0);
    check_val("t6_data_rst", frame_data, 0);
    for (int i = 0; i < 12; i++) step();
    check_val("t6_no_stale_frame", frame_valid, 0);
    run_frame(2'd0, 8'h00, 1'b0, 8'h00);
    check_val("t6_data", frame_data, 8'h00);
    check_val("t6_err", frame_err, 0);
    check_val("t6_cnt", err_count, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("t6_hold_start_valid", frame_valid, 1);
    check_val("t6_hold_start_busy", busy, 1);
    frame_ready = 1'b1;
    start = 1'b1;
    step();
    frame_ready = 1'b0;
    start = 1'b0;
    check_val("t6_accept_start_busy", busy, 0);
    check_val("t6_accept_valid", frame_valid, 0);
    step();
    check_val("t6_idle_stays", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
